fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one synchronous 8-bit FIFO write port among N_REQ producers. Each producer offers data on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `wr_en`/`buf_in` pins. It also honours FIFO backpressure via `buf_full`. It sits directly in front of the team's sync FIFO, in the producer-side datapath.

---
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Grants one producer per burst (capped at MAX_BURST beats) and honours FIFO backpressure.

module fifo_wr_arbiter_lane #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic              busy,
  input  logic              full,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic [DATA_W-1:0] data_masked
);
  assign ready       = sel & busy & ~full;
  assign data_masked = sel ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  output logic [N_REQ-1:0]        grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                    busy
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [3:0]       burst_cnt;

  logic [N_REQ-1:0][DATA_W-1:0] data_lane, data_masked;
  logic                         pick_vld;
  logic [IDW-1:0]               pick_id, cand;
  logic                         cur_valid, cur_last, cap_hit, rel;

  assign data_lane = req_data;

  // Lane select follows grant_id even when idle so wr_data defaults to lane 0 after reset.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .sel         (grant_id == IDW'(i)),
      .busy        (busy),
      .full        (fifo_full),
      .data        (data_lane[i]),
      .ready       (req_ready[i]),
      .data_masked (data_masked[i])
    );
  end

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < N_REQ; i++) fifo_wr_data |= data_masked[i];
  end

  // Walk the circle backwards so the candidate nearest rr_ptr+1 is assigned last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDW'((int'(rr_ptr) + i) % N_REQ);
      if (req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  assign cur_valid  = req_valid[grant_id];
  assign cur_last   = req_last[grant_id];
  assign fifo_wr_en = busy & cur_valid & ~fifo_full;
  assign cap_hit    = ({1'b0, burst_cnt} + 5'd1) == 5'(MAX_BURST);
  // Withdrawal releases even under backpressure; a full FIFO with valid held only stalls.
  assign rel        = ~cur_valid | (fifo_wr_en & (cur_last | cap_hit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(N_REQ - 1);
      burst_cnt <= '0;
      grant     <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= GRANT;
            grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
            grant_id  <= pick_id;
            burst_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          if (fifo_wr_en) burst_cnt <= burst_cnt + 4'd1;
          if (rel) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single burst, round-robin order, burst cap,
// backpressure stall, withdrawal and asynchronous reset mid-burst.
module tb_fifo_wr_arbiter;
  logic        clk, rst;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        fifo_full, fifo_wr_en, busy;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  grant_id;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant(grant),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
  endtask

  logic [7:0] b;

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    cyc(); cyc();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    rst = 1'b0;
    cyc();

    // single requester 2, three beats
    req_valid = 4'b0100; set_data(2, 8'h11); #1;
    chk("t1_idle_grant", 32'(grant), 32'h0);
    chk("t1_idle_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_grant_id", 32'(grant_id), 32'h2);
    chk("t1_ready", 32'(req_ready), 32'h4);
    chk("t1_b1_en", 32'(fifo_wr_en), 32'h1);
    chk("t1_b1_data", 32'(fifo_wr_data), 32'h11);
    cyc();
    set_data(2, 8'h22); #1;
    chk("t1_b2_en", 32'(fifo_wr_en), 32'h1);
    chk("t1_b2_data", 32'(fifo_wr_data), 32'h22);
    cyc();
    set_data(2, 8'h33); req_last = 4'b0100; #1;
    chk("t1_b3_en", 32'(fifo_wr_en), 32'h1);
    chk("t1_b3_data", 32'(fifo_wr_data), 32'h33);
    cyc();
    req_valid = '0; req_last = '0; #1;
    chk("t1_rel_busy", 32'(busy), 32'h0);
    chk("t1_rel_grant", 32'(grant), 32'h0);
    chk("t1_rel_en", 32'(fifo_wr_en), 32'h0);

    // round robin from a fresh reset: order 0,1,2,3,0,1, one write per two cycles
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));
    req_valid = 4'b1111; req_last = 4'b1111; #1;
    chk("t2_idle_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t2_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
      chk("t2_en", 32'(fifo_wr_en), 32'h1);
      chk("t2_data", 32'(fifo_wr_data), 32'(8'hA0 + 8'(k % 4)));
      cyc();
      chk("t2_bubble_en", 32'(fifo_wr_en), 32'h0);
      chk("t2_bubble_busy", 32'(busy), 32'h0);
    end
    req_valid = '0; req_last = '0; #1;
    cyc();

    // burst cap: requester 1 streams 10 beats without last -> 4,4,2
    b = 8'd1; set_data(1, b); req_valid = 4'b0010; #1;
    cyc();
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < ((g == 2) ? 2 : 4); j++) begin
        chk("t3_grant", 32'(grant), 32'h2);
        chk("t3_en", 32'(fifo_wr_en), 32'h1);
        chk("t3_data", 32'(fifo_wr_data), 32'(b));
        cyc();
        b = b + 8'd1;
        if (b > 8'd10) req_valid = '0;
        else set_data(1, b);
        #1;
      end
      if (g < 2) begin
        chk("t3_bubble_busy", 32'(busy), 32'h0);
        chk("t3_bubble_en", 32'(fifo_wr_en), 32'h0);
        cyc();
      end
    end
    chk("t3_withdraw_busy", 32'(busy), 32'h1);
    chk("t3_withdraw_en", 32'(fifo_wr_en), 32'h0);
    cyc();
    chk("t3_end_busy", 32'(busy), 32'h0);

    // backpressure: full for 3 cycles after beat 2; cap must still end after beat 4
    set_data(0, 8'h41); req_valid = 4'b0001; #1;
    cyc();
    chk("t4_b1_en", 32'(fifo_wr_en), 32'h1);
    chk("t4_b1_data", 32'(fifo_wr_data), 32'h41);
    cyc();
    set_data(0, 8'h42); #1;
    chk("t4_b2_en", 32'(fifo_wr_en), 32'h1);
    chk("t4_b2_data", 32'(fifo_wr_data), 32'h42);
    cyc();
    set_data(0, 8'h43); fifo_full = 1'b1; #1;
    for (int j = 0; j < 3; j++) begin
      chk("t4_full_en", 32'(fifo_wr_en), 32'h0);
      chk("t4_full_ready", 32'(req_ready), 32'h0);
      chk("t4_full_grant", 32'(grant), 32'h1);
      cyc();
    end
    fifo_full = 1'b0; #1;
    chk("t4_b3_en", 32'(fifo_wr_en), 32'h1);
    chk("t4_b3_data", 32'(fifo_wr_data), 32'h43);
    chk("t4_b3_ready", 32'(req_ready), 32'h1);
    cyc();
    set_data(0, 8'h44); #1;
    chk("t4_b4_en", 32'(fifo_wr_en), 32'h1);
    chk("t4_b4_data", 32'(fifo_wr_data), 32'h44);
    cyc();
    set_data(0, 8'h45); #1;
    chk("t4_cap_busy", 32'(busy), 32'h0);
    chk("t4_cap_en", 32'(fifo_wr_en), 32'h0);
    req_valid = '0; #1;
    cyc();

    // withdraw: requester 3 drops after one beat, then 0 beats 1 on rr_ptr=3
    set_data(3, 8'h55); req_valid = 4'b1000; #1;
    cyc();
    chk("t5_grant", 32'(grant), 32'h8);
    chk("t5_grant_id", 32'(grant_id), 32'h3);
    chk("t5_b1_data", 32'(fifo_wr_data), 32'h55);
    cyc();
    set_data(0, 8'h60); set_data(1, 8'h70); req_valid = 4'b0011; #1;
    chk("t5_wd_busy", 32'(busy), 32'h1);
    chk("t5_wd_en", 32'(fifo_wr_en), 32'h0);
    cyc();
    chk("t5_rel_busy", 32'(busy), 32'h0);
    cyc();
    chk("t5_next_grant", 32'(grant), 32'h1);
    chk("t5_next_data", 32'(fifo_wr_data), 32'h60);

    // reset during beat 2 of requester 0
    cyc();
    set_data(0, 8'h61); #1;
    chk("t6_b2_en", 32'(fifo_wr_en), 32'h1);
    rst = 1'b1; #1;
    chk("t6_rst_en", 32'(fifo_wr_en), 32'h0);
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    chk("t6_rst_grant_id", 32'(grant_id), 32'h0);
    cyc();
    rst = 1'b0; #1;
    cyc();
    chk("t6_regrant", 32'(grant), 32'h1);
    chk("t6_regrant_data", 32'(fifo_wr_data), 32'h61);
    req_valid = '0; #1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
